// File: rtl/elec_lock_pkg.sv
`default_nettype none
// ============================================================================
// Module      : elec_lock_pkg
// Description : Shared state encoding, result codes and key decode for the
//               electronic lock controller.
// Revision    : 1.0 - initial release
// ============================================================================
package elec_lock_pkg;

    typedef logic [2:0] lock_state_t;

    localparam lock_state_t ST_IDLE    = 3'd0;
    localparam lock_state_t ST_ENTRY   = 3'd1;
    localparam lock_state_t ST_CHECK   = 3'd2;
    localparam lock_state_t ST_OPEN    = 3'd3;
    localparam lock_state_t ST_LOCKOUT = 3'd4;

    localparam logic [1:0] RES_NONE = 2'd0;
    localparam logic [1:0] RES_PASS = 2'd1;
    localparam logic [1:0] RES_FAIL = 2'd2;

    localparam logic [1:0] CODE_NONE = 2'b00;
    localparam logic [1:0] CODE_D1   = 2'b01;
    localparam logic [1:0] CODE_D2   = 2'b10;
    localparam logic [1:0] CODE_D3   = 2'b11;

    localparam int KEY_CONFIRM = 3;

    // Lowest-index digit key wins; CODE_NONE means no digit pressed.
    function automatic logic [1:0] digit_code(input logic [2:0] keys);
        logic [1:0] code;
        code = CODE_NONE;
        if (keys[0])      code = CODE_D1;
        else if (keys[1]) code = CODE_D2;
        else if (keys[2]) code = CODE_D3;
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/elec_lock_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : elec_lock_ctrl_if
// Description : Keypad pulses in, actuator/indicator status out.
// Revision    : 1.0 - initial release
// ============================================================================
interface elec_lock_ctrl_if #(
    parameter int PWD_LEN   = 3,
    parameter int MAX_TRIES = 3
);
    logic [3:0]                       key_pulse;
    logic                             unlock;
    logic                             alarm;
    logic [1:0]                       result;
    logic [$clog2(PWD_LEN+1)-1:0]     digit_cnt;
    logic [$clog2(MAX_TRIES+1)-1:0]   tries_left;

    modport master (
        output key_pulse,
        input  unlock, alarm, result, digit_cnt, tries_left
    );

    modport slave (
        input  key_pulse,
        output unlock, alarm, result, digit_cnt, tries_left
    );
endinterface
`default_nettype wire

// File: rtl/elec_lock_ctrl_timer.sv
`default_nettype none
// ============================================================================
// Module      : lock_timer
// Description : Load-and-count-down timer; done while the count sits at zero.
// Revision    : 1.0 - initial release
// ============================================================================
module lock_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);
    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign done = (r_count == '0);
endmodule
`default_nettype wire

// File: rtl/elec_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : elec_lock_ctrl
// Description : Keypad code-lock sequencer: digit buffer, check, unlock window
//               and failed-try lockout.
// Revision    : 1.0 - initial release
// ============================================================================
module elec_lock_ctrl
    import elec_lock_pkg::*;
#(
    parameter int                   PWD_LEN        = 3,
    parameter logic [2*PWD_LEN-1:0] PASSWORD       = 6'b100111,
    parameter int                   OPEN_CYCLES    = 50_000_000,
    parameter int                   LOCKOUT_CYCLES = 250_000_000,
    parameter int                   ENTRY_TIMEOUT  = 250_000_000,
    parameter int                   MAX_TRIES      = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    elec_lock_ctrl_if.slave lock_if
);
    localparam int c_DCW    = $clog2(PWD_LEN + 1);
    localparam int c_TW     = $clog2(MAX_TRIES + 1);
    localparam int c_TMAX_A = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
    localparam int c_TMAX   = (c_TMAX_A > ENTRY_TIMEOUT) ? c_TMAX_A : ENTRY_TIMEOUT;
    localparam int c_TMR_W  = (c_TMAX > 1) ? $clog2(c_TMAX) : 1;

    localparam logic [c_DCW-1:0] c_PWD_CNT   = c_DCW'(PWD_LEN);
    localparam logic [c_TW-1:0]  c_TRIES_MAX = c_TW'(MAX_TRIES);

    logic                 r_confirm;
    logic [1:0]           r_code;
    lock_state_t          r_state, w_state_nxt;
    logic [2*PWD_LEN-1:0] r_buf, w_buf_nxt, w_buf_shift;
    logic [c_DCW-1:0]     r_digit_cnt, w_digit_cnt_nxt;
    logic [c_TW-1:0]      r_tries, w_tries_nxt;
    logic [1:0]           r_result, w_result_nxt;
    logic                 r_unlock, r_alarm;
    logic                 w_digit, w_match, w_key_load, w_timer_load, w_timer_done;
    logic [c_TMR_W-1:0]   w_load_val;

    // Keys are registered first so no output depends combinationally on them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_confirm <= 1'b0;
            r_code    <= CODE_NONE;
        end else begin
            r_confirm <= lock_if.key_pulse[KEY_CONFIRM];
            r_code    <= lock_if.key_pulse[KEY_CONFIRM] ? CODE_NONE
                                                        : digit_code(lock_if.key_pulse[2:0]);
        end
    end

    generate
        if (PWD_LEN == 1) begin : g_buf_single
            assign w_buf_shift = r_code;
        end else begin : g_buf_multi
            assign w_buf_shift = {r_buf[2*PWD_LEN-3:0], r_code};
        end
    endgenerate

    assign w_digit = (r_code != CODE_NONE);
    assign w_match = (r_digit_cnt == c_PWD_CNT) && (r_buf == PASSWORD);

    always_comb begin
        w_state_nxt     = r_state;
        w_buf_nxt       = r_buf;
        w_digit_cnt_nxt = r_digit_cnt;
        w_tries_nxt     = r_tries;
        w_result_nxt    = r_result;
        w_key_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_confirm) begin
                    w_state_nxt = ST_CHECK;
                end else if (w_digit) begin
                    w_buf_nxt       = w_buf_shift;
                    w_digit_cnt_nxt = c_DCW'(1);
                    w_state_nxt     = ST_ENTRY;
                end
            end
            ST_ENTRY: begin
                if (r_confirm) begin
                    w_state_nxt = ST_CHECK;
                end else if (w_digit) begin
                    w_buf_nxt       = w_buf_shift;
                    w_digit_cnt_nxt = (r_digit_cnt == c_PWD_CNT) ? r_digit_cnt
                                                                 : r_digit_cnt + c_DCW'(1);
                    w_key_load      = 1'b1;
                end else if (w_timer_done) begin
                    w_buf_nxt       = '0;
                    w_digit_cnt_nxt = '0;
                    w_state_nxt     = ST_IDLE;
                end
            end
            ST_CHECK: begin
                w_buf_nxt       = '0;
                w_digit_cnt_nxt = '0;
                if (w_match) begin
                    w_result_nxt = RES_PASS;
                    w_tries_nxt  = c_TRIES_MAX;
                    w_state_nxt  = ST_OPEN;
                end else begin
                    w_result_nxt = RES_FAIL;
                    w_tries_nxt  = r_tries - c_TW'(1);
                    w_state_nxt  = (r_tries == c_TW'(1)) ? ST_LOCKOUT : ST_IDLE;
                end
            end
            ST_OPEN: begin
                if (r_confirm || w_timer_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LOCKOUT: begin
                if (w_timer_done) begin
                    w_tries_nxt = c_TRIES_MAX;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // One timer serves all windows: reload on any state change or new digit.
    assign w_timer_load = (w_state_nxt != r_state) || w_key_load;

    always_comb begin
        case (w_state_nxt)
            ST_ENTRY:   w_load_val = c_TMR_W'(ENTRY_TIMEOUT - 1);
            ST_OPEN:    w_load_val = c_TMR_W'(OPEN_CYCLES - 1);
            ST_LOCKOUT: w_load_val = c_TMR_W'(LOCKOUT_CYCLES - 1);
            default:    w_load_val = '0;
        endcase
    end

    lock_timer #(
        .WIDTH (c_TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_timer_load),
        .load_val (w_load_val),
        .done     (w_timer_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_buf       <= '0;
            r_digit_cnt <= '0;
            r_tries     <= c_TRIES_MAX;
            r_result    <= RES_NONE;
            r_unlock    <= 1'b0;
            r_alarm     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_buf       <= w_buf_nxt;
            r_digit_cnt <= w_digit_cnt_nxt;
            r_tries     <= w_tries_nxt;
            r_result    <= w_result_nxt;
            r_unlock    <= (w_state_nxt == ST_OPEN);
            r_alarm     <= (w_state_nxt == ST_LOCKOUT);
        end
    end

    assign lock_if.unlock     = r_unlock;
    assign lock_if.alarm      = r_alarm;
    assign lock_if.result     = r_result;
    assign lock_if.digit_cnt  = r_digit_cnt;
    assign lock_if.tries_left = r_tries;
endmodule
`default_nettype wire

// File: tb/tb_elec_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_elec_lock_ctrl
// Description : Directed bench for elec_lock_ctrl with a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_elec_lock_ctrl;
    localparam int         PWD_LEN   = 3;
    localparam logic [5:0] PASSWORD  = 6'b100111;
    localparam int         OPEN_C    = 8;
    localparam int         LOCK_C    = 16;
    localparam int         TIMEOUT_C = 10;
    localparam int         MAX_TRIES = 3;

    localparam logic [3:0] K0 = 4'b0001;
    localparam logic [3:0] K1 = 4'b0010;
    localparam logic [3:0] K2 = 4'b0100;
    localparam logic [3:0] KC = 4'b1000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    bit   chk_en = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    elec_lock_ctrl_if #(.PWD_LEN(PWD_LEN), .MAX_TRIES(MAX_TRIES)) bus ();

    elec_lock_ctrl #(
        .PWD_LEN        (PWD_LEN),
        .PASSWORD       (PASSWORD),
        .OPEN_CYCLES    (OPEN_C),
        .LOCKOUT_CYCLES (LOCK_C),
        .ENTRY_TIMEOUT  (TIMEOUT_C),
        .MAX_TRIES      (MAX_TRIES)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .lock_if (bus)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Model: digits kept as a list; the keypad is seen one cycle late.
    int q[$];
    int m_evt   = -1;
    bit m_check = 1'b0;
    int m_open  = 0;
    int m_lock  = 0;
    int m_idle  = 0;
    int m_tries = MAX_TRIES;
    int m_result = 0;

    function automatic int decode(input logic [3:0] k);
        if (k[3]) return 3;
        if (k[0]) return 0;
        if (k[1]) return 1;
        if (k[2]) return 2;
        return -1;
    endfunction

    function automatic bit model_match();
        logic [5:0] pw;
        int base;
        pw = PASSWORD;
        if (q.size() < PWD_LEN) return 1'b0;
        base = q.size() - PWD_LEN;
        for (int i = 0; i < PWD_LEN; i++)
            if (q[base+i] != int'(pw[2*(PWD_LEN-1-i) +: 2])) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk or negedge rst_n) begin : p_model
        int ev;
        if (!rst_n) begin
            q.delete();
            m_evt = -1; m_check = 1'b0; m_open = 0; m_lock = 0; m_idle = 0;
            m_tries = MAX_TRIES; m_result = 0;
        end else begin
            ev    = m_evt;
            m_evt = decode(bus.key_pulse);
            if (m_check) begin
                m_check = 1'b0;
                if (model_match()) begin
                    m_result = 1; m_tries = MAX_TRIES; m_open = OPEN_C;
                end else begin
                    m_result = 2; m_tries--;
                    if (m_tries == 0) m_lock = LOCK_C;
                end
                q.delete();
                m_idle = 0;
            end else if (m_lock > 0) begin
                m_lock--;
                if (m_lock == 0) m_tries = MAX_TRIES;
            end else if (m_open > 0) begin
                if (ev == 3) m_open = 0;
                else         m_open--;
            end else if (ev == 3) begin
                m_check = 1'b1;
            end else if (ev >= 0) begin
                q.push_back(ev + 1);
                m_idle = 0;
            end else if (q.size() > 0) begin
                m_idle++;
                if (m_idle == TIMEOUT_C) begin
                    q.delete();
                    m_idle = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_unlock", bus.unlock, 32'(m_open > 0));
            chk("cyc_alarm", bus.alarm, 32'(m_lock > 0));
            chk("cyc_result", bus.result, m_result);
            chk("cyc_digit_cnt", bus.digit_cnt, (q.size() > PWD_LEN) ? PWD_LEN : q.size());
            chk("cyc_tries", bus.tries_left, m_tries);
            if (bus.unlock && bus.alarm) chk("cyc_exclusive", 1, 0);
        end
    end

    task automatic drive(input logic [3:0] k);
        bus.key_pulse = k;
        @(posedge clk);
        #1;
        bus.key_pulse = 4'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic enter_code();
        drive(K1); drive(K0); drive(K2);
    endtask

    initial begin : p_stim
        int cnt;
        bus.key_pulse = 4'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_unlock", bus.unlock, 0);
        chk("rst_alarm", bus.alarm, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_digit_cnt", bus.digit_cnt, 0);
        chk("rst_tries", bus.tries_left, 3);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        idle(2);

        // Correct code, two-edge latency, 8-cycle window
        enter_code();
        drive(KC);
        chk("entry_cnt", bus.digit_cnt, 3);
        idle(1);
        chk("pass_not_yet", bus.result, 0);
        idle(1);
        chk("pass_result", bus.result, 1);
        chk("pass_unlock", bus.unlock, 1);
        chk("pass_tries", bus.tries_left, 3);
        cnt = 0;
        for (int i = 0; i < 20 && bus.unlock; i++) begin
            cnt++;
            idle(1);
        end
        chk("open_window", cnt, 8);

        // Wrong code
        drive(K0); drive(K0); drive(K0); drive(KC);
        idle(2);
        chk("wrong_result", bus.result, 2);
        chk("wrong_tries", bus.tries_left, 2);
        chk("wrong_unlock", bus.unlock, 0);
        idle(2);

        // Two more failures -> lockout, keys ignored inside
        drive(KC); idle(2);
        chk("fail2_tries", bus.tries_left, 1);
        drive(KC); idle(2);
        chk("lock_alarm", bus.alarm, 1);
        cnt = 0;
        for (int i = 0; i < 40 && bus.alarm; i++) begin
            cnt++;
            bus.key_pulse = (i < 8) ? ((i % 2 == 1) ? KC : K1) : 4'b0;
            idle(1);
        end
        bus.key_pulse = 4'b0;
        chk("lock_window", cnt, 16);
        chk("lock_exit_tries", bus.tries_left, 3);
        chk("lock_exit_result", bus.result, 2);
        chk("lock_exit_cnt", bus.digit_cnt, 0);

        // Correct code after lockout, then early relock
        enter_code(); drive(KC); idle(2);
        chk("relock_pass", bus.result, 1);
        drive(KC);
        chk("relock_still_open", bus.unlock, 1);
        idle(1);
        chk("relock_closed", bus.unlock, 0);
        idle(2);

        // Short entry fails, long entry passes on the last three digits
        drive(K1); drive(K0); drive(KC); idle(2);
        chk("short_result", bus.result, 2);
        chk("short_tries", bus.tries_left, 2);
        drive(K0); drive(K1); drive(K0); drive(K2); drive(KC); idle(2);
        chk("long_result", bus.result, 1);
        chk("long_tries", bus.tries_left, 3);
        chk("long_cnt_clear", bus.digit_cnt, 0);
        idle(10);

        // Entry timeout
        drive(K2);
        idle(10);
        chk("timeout_before", bus.digit_cnt, 1);
        idle(1);
        chk("timeout_cnt", bus.digit_cnt, 0);
        chk("timeout_tries", bus.tries_left, 3);

        // Lowest-index digit wins among simultaneous digits
        drive(KC); idle(2);
        chk("prio_pre_fail", bus.result, 2);
        drive(K1 | K2); drive(K0 | K1); drive(K2); drive(KC); idle(2);
        chk("prio_digit_pass", bus.result, 1);
        drive(KC); idle(2);

        // Confirm beats a digit in the same cycle
        drive(KC); idle(2);
        chk("prio_pre_fail2", bus.result, 2);
        enter_code(); drive(KC | K0); idle(2);
        chk("prio_confirm_pass", bus.result, 1);
        chk("prio_confirm_unlock", bus.unlock, 1);
        drive(KC); idle(2);

        // Asynchronous reset during lockout
        drive(KC); idle(2); drive(KC); idle(2); drive(KC); idle(2);
        chk("rst_pre_alarm", bus.alarm, 1);
        idle(5);
        rst_n = 1'b0;
        #1;
        chk("arst_alarm", bus.alarm, 0);
        chk("arst_result", bus.result, 0);
        chk("arst_tries", bus.tries_left, 3);
        chk("arst_unlock", bus.unlock, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(3);
        enter_code(); drive(KC); idle(2);
        chk("post_rst_pass", bus.result, 1);
        idle(10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
